// File: rtl/cv_pe_tile_seq.sv
// PE tile output sequencer: walks an O x H x W tile, reads the tile buffer and streams elements with coordinates.
// Optional ReLU on the write path into the skid buffer is enabled by defining CV_PE_ACT_EN.
module cv_pe_tile_seq #(
  parameter int DW  = 16,
  parameter int AW  = 13,
  parameter int IDW = 8,
  parameter int RAW = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IDW-1:0] id,
  input  logic [IDW-1:0] cfg_id,
  input  logic           broadcast,
  input  logic           cfg,
  input  logic [AW-1:0]  cfg_Oext,
  input  logic [AW-1:0]  cfg_Hext,
  input  logic [AW-1:0]  cfg_Wext,
  input  logic [AW-1:0]  cfg_Oori,
  input  logic [AW-1:0]  cfg_Hori,
  input  logic [AW-1:0]  cfg_Wori,
  output logic [AW-1:0]  Oext,
  output logic [AW-1:0]  Hext,
  output logic [AW-1:0]  Wext,
  output logic [AW-1:0]  Oori,
  output logic [AW-1:0]  Hori,
  output logic [AW-1:0]  Wori,
  input  logic           store_output,
  output logic           idle,
  output logic           calc_done,
  output logic           rd_en,
  output logic [RAW-1:0] rd_addr,
  input  logic [DW-1:0]  rd_data,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic [DW-1:0]  dout_data,
  output logic [AW-1:0]  dout_o,
  output logic [AW-1:0]  dout_h,
  output logic [AW-1:0]  dout_w,
  output logic           dout_last,
  input  logic [1:0]     act_type
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam int MW = 1 + 3*AW;
  localparam int EW = MW + DW;

  logic [1:0]    state;
  logic [AW-1:0] o_cnt, h_cnt, w_cnt;
  logic          pend;
  logic [MW-1:0] pend_meta;
  logic [1:0]    count;
  logic [EW-1:0] ent0, ent1, in_ent, head;
  logic          zero_done;
  logic [DW-1:0] act_data;
  logic          cfg_hit, start, ext_zero, last_pt, pop, issue;
  logic [2:0]    occ;

`ifdef CV_PE_ACT_EN
  assign act_data = (act_type == 2'd1 && rd_data[DW-1]) ? '0 : rd_data;
`else
  logic unused_act;
  assign unused_act = ^act_type;
  assign act_data   = rd_data;
`endif

  assign cfg_hit  = cfg && (broadcast || cfg_id == id) && state == S_IDLE;
  assign start    = store_output && state == S_IDLE;
  assign ext_zero = (Oext == '0) || (Hext == '0) || (Wext == '0);
  assign last_pt  = (o_cnt == Oext - AW'(1)) && (h_cnt == Hext - AW'(1)) && (w_cnt == Wext - AW'(1));

  // Head of queue: oldest held entry, else the read returning this cycle (bypass keeps latency at one cycle).
  assign in_ent = {pend_meta, act_data};
  always_comb begin
    head = '0;
    if (count != 2'd0) head = ent0;
    else if (pend)     head = in_ent;
  end
  assign {dout_last, dout_o, dout_h, dout_w, dout_data} = head;
  assign dout_valid = (count != 2'd0) || pend;
  assign pop        = dout_valid && dout_ready;

  // Occupancy after this edge, before counting a new read; a new read must still fit in two slots.
  assign occ   = {1'b0, count} + {2'b0, pend} - {2'b0, pop};
  assign issue = (state == S_RUN) && (occ <= 3'd1);
  assign rd_en = issue;

  assign idle      = (state == S_IDLE);
  assign calc_done = zero_done || (state == S_DRAIN && pop && dout_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      {Oext, Hext, Wext, Oori, Hori, Wori} <= '0;
      o_cnt     <= '0;
      h_cnt     <= '0;
      w_cnt     <= '0;
      rd_addr   <= '0;
      pend      <= 1'b0;
      pend_meta <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= start && ext_zero;
      if (cfg_hit) begin
        Oext <= cfg_Oext;
        Hext <= cfg_Hext;
        Wext <= cfg_Wext;
        Oori <= cfg_Oori;
        Hori <= cfg_Hori;
        Wori <= cfg_Wori;
      end
      pend <= issue;
      if (issue) pend_meta <= {last_pt, Oori + o_cnt, Hori + h_cnt, Wori + w_cnt};
      case (state)
        S_IDLE: begin
          if (start && !ext_zero) begin
            state   <= S_RUN;
            o_cnt   <= '0;
            h_cnt   <= '0;
            w_cnt   <= '0;
            rd_addr <= '0;
          end
        end
        S_RUN: begin
          if (issue) begin
            rd_addr <= rd_addr + RAW'(1);
            if (w_cnt == Wext - AW'(1)) begin
              w_cnt <= '0;
              if (h_cnt == Hext - AW'(1)) begin
                h_cnt <= '0;
                o_cnt <= o_cnt + AW'(1);
              end else begin
                h_cnt <= h_cnt + AW'(1);
              end
            end else begin
              w_cnt <= w_cnt + AW'(1);
            end
            if (last_pt) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && dout_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Two-entry queue: ent0 is oldest; a returning read is stored only if it is not consumed by bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      count <= count + {1'b0, pend} - {1'b0, pop};
      case (count)
        2'd0: begin
          if (pend && !pop) ent0 <= in_ent;
        end
        2'd1: begin
          if (pop && pend)       ent0 <= in_ent;
          else if (!pop && pend) ent1 <= in_ent;
        end
        default: begin
          if (pop) begin
            ent0 <= ent1;
            if (pend) ent1 <= in_ent;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cv_pe_tile_seq.sv
// Directed bench for cv_pe_tile_seq: config filter, streaming with/without backpressure, empty tile, mid-run reset.
module tb_cv_pe_tile_seq;
  logic        clk;
  logic        rst;
  logic [7:0]  id, cfg_id;
  logic        broadcast, cfg;
  logic [12:0] cfg_Oext, cfg_Hext, cfg_Wext, cfg_Oori, cfg_Hori, cfg_Wori;
  logic [12:0] Oext, Hext, Wext, Oori, Hori, Wori;
  logic        store_output, idle, calc_done, rd_en;
  logic [11:0] rd_addr;
  logic [15:0] rd_data;
  logic        dout_valid, dout_ready, dout_last;
  logic [15:0] dout_data;
  logic [12:0] dout_o, dout_h, dout_w;
  logic [1:0]  act_type;

  int n_assert = 0;
  int n_fail   = 0;

  cv_pe_tile_seq dut (
    .clk(clk), .rst(rst), .id(id), .cfg_id(cfg_id), .broadcast(broadcast), .cfg(cfg),
    .cfg_Oext(cfg_Oext), .cfg_Hext(cfg_Hext), .cfg_Wext(cfg_Wext),
    .cfg_Oori(cfg_Oori), .cfg_Hori(cfg_Hori), .cfg_Wori(cfg_Wori),
    .Oext(Oext), .Hext(Hext), .Wext(Wext), .Oori(Oori), .Hori(Hori), .Wori(Wori),
    .store_output(store_output), .idle(idle), .calc_done(calc_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_o(dout_o), .dout_h(dout_h), .dout_w(dout_w), .dout_last(dout_last),
    .act_type(act_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_val(input logic [11:0] a);
    if (a == 12'd0) return 16'hFFF0;
    if (a == 12'd1) return 16'h0010;
    return 16'h0100 + {4'h0, a};
  endfunction

  // Tile buffer: data appears one cycle after the read strobe.
  always @(posedge clk) if (rd_en) rd_data <= mem_val(rd_addr);

  function automatic logic [15:0] exp_data(input int k);
    logic [15:0] v;
    v = mem_val(12'(k));
`ifdef CV_PE_ACT_EN
    if (v[15]) v = 16'h0000;
`endif
    return v;
  endfunction

  // Tile 2x2x3 at origin (4,0,8): w fastest, then h, then o.
  function automatic logic [63:0] exp_head(input int k);
    logic [12:0] eo, eh, ew;
    eo = 13'(4 + k / 6);
    eh = 13'((k / 3) % 2);
    ew = 13'(8 + k % 3);
    return {8'h00, (k == 11), eo, eh, ew, exp_data(k)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cfg(input logic [12:0] wext);
    @(negedge clk);
    cfg = 1'b1; broadcast = 1'b1;
    cfg_Oext = 13'd2; cfg_Hext = 13'd2; cfg_Wext = wext;
    cfg_Oori = 13'd4; cfg_Hori = 13'd0; cfg_Wori = 13'd8;
    @(negedge clk);
    cfg = 1'b0; broadcast = 1'b0;
  endtask

  task automatic run_stream(input int mode);
    int issued, got, popped_pre, first_rd, cyc_now;
    logic prev_stall;
    logic [63:0] prev_head, cur_head;
    issued = 0; got = 0; first_rd = -1; prev_stall = 1'b0; prev_head = '0;
    @(negedge clk);
    store_output = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      store_output = 1'b0;
      if (mode == 0)   dout_ready = 1'b1;
      else if (c < 16) dout_ready = (c % 4 == 0) || (c % 4 == 3);
      else             dout_ready = 1'($urandom_range(0, 1));
      #1;
      cyc_now = c;
      cur_head = {8'h00, dout_last, dout_o, dout_h, dout_w, dout_data};
      popped_pre = got;
      chk("skid_occupancy", 64'((issued + int'(rd_en) - popped_pre - int'(dout_valid && dout_ready)) <= 2), 64'd1);
      if (rd_en) begin
        chk("rd_addr", 64'(rd_addr), 64'(issued));
        if (first_rd < 0) first_rd = cyc_now;
        issued++;
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(dout_valid), 64'd1);
        chk("stall_hold", cur_head, prev_head);
      end
      if (dout_valid && dout_ready) begin
        chk("element", cur_head, exp_head(got));
        chk("done_on_last", 64'(calc_done), 64'(got == 11));
        if (mode == 0) chk("throughput", 64'(cyc_now), 64'(first_rd + 1 + got));
        got++;
      end else begin
        chk("no_early_done", 64'(calc_done), 64'd0);
      end
      prev_stall = dout_valid && !dout_ready;
      prev_head  = cur_head;
      if (got == 12) break;
    end
    chk("element_count", 64'(got), 64'd12);
    chk("read_count", 64'(issued), 64'd12);
    @(negedge clk);
    #1;
    chk("post_idle", {idle, dout_valid, calc_done, rd_en}, 64'b1000);
  endtask

  initial begin
    int got;
    rst = 1'b1; id = 8'h05; cfg_id = 8'h06; broadcast = 1'b0; cfg = 1'b0;
    cfg_Oext = '0; cfg_Hext = '0; cfg_Wext = '0; cfg_Oori = '0; cfg_Hori = '0; cfg_Wori = '0;
    store_output = 1'b0; dout_ready = 1'b1; act_type = 2'd1; rd_data = 16'h0000;

    @(negedge clk);
    chk("rst_ctrl", {idle, calc_done, rd_en, dout_valid, dout_last}, 64'b10000);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_dout", {dout_data, dout_o, dout_h, dout_w}, 64'd0);
    chk("rst_cfg_ext", {Oext, Hext, Wext}, 64'd0);
    chk("rst_cfg_ori", {Oori, Hori, Wori}, 64'd0);
    rst = 1'b0;

    // Id mismatch without broadcast must not load.
    @(negedge clk);
    cfg = 1'b1; broadcast = 1'b0;
    cfg_Oext = 13'd2; cfg_Hext = 13'd2; cfg_Wext = 13'd3;
    cfg_Oori = 13'd4; cfg_Hori = 13'd0; cfg_Wori = 13'd8;
    @(negedge clk);
    cfg = 1'b0;
    chk("cfg_mismatch_ext", {Oext, Hext, Wext}, 64'd0);
    chk("cfg_mismatch_ori", {Oori, Hori, Wori}, 64'd0);

    do_cfg(13'd3);
    chk("cfg_bcast_ext", {Oext, Hext, Wext}, {25'd0, 13'd2, 13'd2, 13'd3});
    chk("cfg_bcast_ori", {Oori, Hori, Wori}, {25'd0, 13'd4, 13'd0, 13'd8});

    run_stream(0);
    run_stream(1);
    dout_ready = 1'b1;

    // Empty tile: only a done pulse on the following cycle.
    do_cfg(13'd0);
    @(negedge clk);
    store_output = 1'b1;
    #1;
    chk("zero_start", {calc_done, rd_en, dout_valid}, 64'b000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      store_output = 1'b0;
      #1;
      chk("zero_done", 64'(calc_done), 64'(i == 0));
      chk("zero_quiet", {rd_en, dout_valid, idle}, 64'b001);
    end

    // Reset after the fifth element, then a clean restart.
    do_cfg(13'd3);
    dout_ready = 1'b1;
    got = 0;
    @(negedge clk);
    store_output = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      store_output = 1'b0;
      #1;
      if (dout_valid && dout_ready) got++;
      if (got == 5) break;
    end
    chk("rst_after5_count", 64'(got), 64'd5);
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", {idle, calc_done, rd_en, dout_valid, dout_last}, 64'b10000);
    chk("midrst_addr_data", {rd_addr, dout_data}, 64'd0);
    chk("midrst_coords", {dout_o, dout_h, dout_w}, 64'd0);
    chk("midrst_cfg", {Oext, Hext, Wext}, 64'd0);
    @(negedge clk);
    chk("midrst_hold", {calc_done, dout_valid, rd_en}, 64'b000);
    rst = 1'b0;
    do_cfg(13'd3);
    run_stream(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cv_pe_tile_seq.md
CV_PE_TILE_SEQ -- requirements
Module: cv_pe_tile_seq

Interface
REQ-001 Parameter DW, default 16: output data width.
REQ-002 Parameter AW, default 13: extent/origin field width.
REQ-003 Parameter IDW, default 8: PE id width.
REQ-004 Parameter RAW, default 12: tile buffer address width.
REQ-005 clk  in  1  sole clock; all state SHALL be on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 id  in  IDW  this PE's id; cfg_id  in  IDW  target id; broadcast  in  1  ignore id match.
REQ-008 cfg  in  1  config strobe; cfg_Oext/cfg_Hext/cfg_Wext/cfg_Oori/cfg_Hori/cfg_Wori  in  AW each.
REQ-009 Oext/Hext/Wext/Oori/Hori/Wori  out  AW each  latched config.
REQ-010 store_output  in  1  start pulse; idle  out  1; calc_done  out  1  one-cycle done pulse.
REQ-011 rd_en  out  1; rd_addr  out  RAW; rd_data  in  DW  (valid exactly 1 cycle after rd_en).
REQ-012 dout_valid  out  1; dout_ready  in  1; dout_data  out  DW; dout_o/dout_h/dout_w  out  AW; dout_last  out  1.
REQ-013 act_type  in  2  activation select.

Function
REQ-014 Config accepted when cfg=1 AND (broadcast=1 OR cfg_id==id) AND state==IDLE; all six registers SHALL load together next edge; otherwise they SHALL hold.
REQ-015 FSM states IDLE, RUN, DRAIN; idle=1 only in IDLE.
REQ-016 IDLE->RUN on store_output=1; store_output outside IDLE SHALL be ignored.
REQ-017 If any of Oext/Hext/Wext is 0 at start: no reads, no outputs; calc_done SHALL pulse the cycle after store_output; stay IDLE.
REQ-018 RUN iterates w fastest, then h, then o; offsets start at 0; one rd_en per cycle when downstream has room.
REQ-019 rd_addr SHALL start at 0 and increment by 1 per issued read, wrapping modulo 2^RAW.
REQ-020 Coordinates: dout_o=Oori+o, dout_h=Hori+h, dout_w=Wori+w, truncated to AW.
REQ-021 Read-to-dout latency SHALL be exactly 1 cycle when dout_ready stays 1; full throughput 1 element/cycle.
REQ-022 2-entry skid buffer: rd_en SHALL be 0 whenever in-flight read plus held entries would exceed 2; no element lost or duplicated under any dout_ready pattern.
REQ-023 dout_data/coords SHALL be stable while dout_valid=1 and dout_ready=0.
REQ-024 dout_last=1 only on element (Oext-1, Hext-1, Wext-1).
REQ-025 After last read, RUN->DRAIN; DRAIN->IDLE when last element handshakes; calc_done SHALL pulse that same cycle.
REQ-026 Transfer occurs only on dout_valid AND dout_ready.

Reset
REQ-027 On rst: state IDLE, idle=1, calc_done=0, rd_en=0, rd_addr=0, dout_valid=0, dout_last=0, dout_data/coords=0, all config outputs=0.
REQ-028 rst mid-RUN/DRAIN SHALL discard in-flight and buffered elements immediately; no calc_done emitted.

Configuration
REQ-029 Macro CV_PE_ACT_EN defined: act_type=1 SHALL output ReLU (signed rd_data<0 -> 0); act_type 0,2,3 pass-through; applied on write into skid buffer.
REQ-030 CV_PE_ACT_EN undefined: dout_data=rd_data unchanged; act_type ignored; no activation logic present.

Verification
REQ-031 cfg=1, broadcast=0, cfg_id!=id -> config outputs unchanged; repeat with broadcast=1 -> loads Oext=2,Hext=2,Wext=3, Oori=4,Hori=0,Wori=8.
REQ-032 Ext 2x2x3, dout_ready=1 -> 12 outputs on consecutive cycles, rd_addr 0..11, first (4,0,8), last (5,1,10) with dout_last=1, calc_done same cycle.
REQ-033 Same tile, dout_ready toggling 1-0-0-1 random -> identical 12-element sequence, rd_en never overruns skid, data held while stalled.
REQ-034 Wext=0 then store_output -> zero rd_en, zero dout_valid, calc_done pulse next cycle.
REQ-035 rst asserted after 5th output -> all outputs at reset values same cycle; new store_output restarts at rd_addr=0.
REQ-036 CV_PE_ACT_EN, act_type=1, rd_data=16'hFFF0 -> dout_data=0; rd_data=16'h0010 -> 16'h0010.
